s100_bus_ctrl: RTL
==================

Name: s100_bus_ctrl

Overview:
- Parametrised S-100 bus controller between the i8080 core and its memory/IO slaves.
- Generates the CPU clock enable and latches the status byte on sync.
- Decodes NUM_MEM memory windows and NUM_IO port windows, and muxes read data back to the CPU.
- Adds a turn-key boot overlay and per-region wait-state insertion.

Parameters:
- CE_DIV, 2, clk cycles per ce pulse (2..15).
- NUM_MEM, 4, memory windows (1..8).
- NUM_IO, 2, IO windows (1..8).
- MEM_BASE, {NUM_MEM{8'h00}}, packed 8-bit page base per window (window i = bits [8i+7:8i]).
- MEM_MASK, {NUM_MEM{8'hFF}}, packed 8-bit page care-mask per window.
- MEM_RO, {NUM_MEM{1'b0}}, per-window read-only bit.
- MEM_WAIT, {NUM_MEM{4'h0}}, packed 4-bit wait states per window, in ce periods.
- IO_BASE, {NUM_IO{8'h00}}, packed 8-bit port base.
- IO_MASK, {NUM_IO{8'hFE}}, packed 8-bit port care-mask.
- BOOT_READS, 3, memory reads served by the boot overlay after reset (1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- addr  in  16  CPU address
- odata  in  8  CPU data out (status byte during sync)
- sync  in  1  CPU status strobe
- rd  in  1  CPU read strobe, active high
- wr_n  in  1  CPU write strobe, active low
- ce  out  1  CPU clock enable
- sysctl  out  8  latched status byte
- idata  out  8  read data to CPU
- mem_rd  out  NUM_MEM  per-window read strobe
- mem_wr  out  NUM_MEM  per-window write strobe
- mem_rdata  in  8*NUM_MEM  packed window read data
- io_rd  out  NUM_IO  per-port-window read strobe
- io_wr  out  NUM_IO  per-port-window write strobe
- io_rdata  in  8*NUM_IO  packed IO read data
- boot_rd  out  1  boot overlay read strobe
- boot_rdata  in  8  boot overlay data
- boot_active  out  1  overlay enabled

Behaviour:
- Reset values: all registers clear (div_cnt=0, wait_cnt=0, sysctl=8'h00, boot_cnt=0, rd_q=0) except boot_active=1. Outputs during reset: ce=0, all strobes 0, idata=8'hFF.
- Clock enable:
  - div_cnt counts 0..CE_DIV-1 and wraps.
  - ce=1 combinationally when div_cnt==CE_DIV-1 and wait_cnt==0.
- sysctl: loads odata on clk when sync&&ce.
- Cycle classification: IO cycle when sysctl[6] (INP, read) or sysctl[4] (OUT, write); otherwise memory cycle.
- Memory window i matches when (addr[15:8]&MASK_i)==(BASE_i&MASK_i). IO window j matches when (addr[7:0]&IOMASK_j)==(IOBASE_j&IOMASK_j).
- Overlap and misses:
  - Lowest index wins; at most one strobe bit is set.
  - No match: no strobe, idata=8'hFF.
- Reads:
  - Boot read: boot_active, memory cycle, rd=1 → boot_rd=rd, idata=boot_rdata, any address, all mem_rd=0.
  - Otherwise mem_rd[i]=rd for the matching window on memory cycles; io_rd[j]=rd on sysctl[6] cycles. idata = the matching slave's data.
- Writes:
  - mem_wr[i]=~wr_n on memory cycles unless MEM_RO[i]. Read-only writes are silently dropped.
  - io_wr[j]=~wr_n when sysctl[4].
  - The boot overlay never affects writes.
- Boot overlay:
  - rd_q registers rd.
  - Each falling edge of rd (rd_q&&!rd) while boot_rd was active increments boot_cnt.
  - When boot_cnt reaches BOOT_READS, boot_active clears the next clk and stays 0 until reset_n is asserted.
- Wait states:
  - On sync&&ce, decode addr as a memory cycle. If window i matches, odata[6]==0 and odata[4]==0, load wait_cnt=MEM_WAIT[i].
  - wait_cnt decrements on each div_cnt wrap while nonzero, holding ce low.
  - MEM_WAIT=0 → no stretch. Boot reads never wait.
- Mid-operation reset: asynchronously clears the wait counter and restarts the overlay.
- Simultaneous boot count-out and a new read: the new read is decoded normally on the cycle after clear.

Optional Feature:
- Macro: S100_WAIT_STATES_EN.
- Defined: wait-state logic as above.
- Undefined: wait_cnt is absent, MEM_WAIT is ignored, and ce is a pure 1-in-CE_DIV pulse.

Test Plan:
- Reset, CE_DIV=2: ce toggles 0,1,0,1; sysctl=00; boot_active=1; idata=FF while idle.
- Boot overlay: 3 reads at 0x1234/0x1235/0x1236 → boot_rd pulses and idata=boot_rdata each time; boot_active=0 after the third rd fall. A fourth read at 0x0000 → mem_rd[0]=1.
- Decode: window0 base 00 mask E0, window2 base FD mask FF RO. Read 0xFD10 → mem_rd[2], idata=mem_rdata[2]. Write 0xFD10 → mem_wr=0. Write 0x1FFF → mem_wr[0]=1.
- IO: sysctl=8'h40, addr=0x1111, io window1 base 10 mask FE, rd=1 → io_rd[1]=1, idata=io_rdata[1]. sysctl=8'h10, wr_n=0 → io_wr[1]=1.
- Wait states (macro on): window1 MEM_WAIT=3, CE_DIV=2. Sync at an address in window1 → next ce delayed by exactly 6 clk. Macro off → no delay.
- Async reset asserted mid-wait → ce=0, wait_cnt=0, boot_active=1 immediately. On release, ce resumes on the second clk.

Source files
------------

// File: rtl/s100_bus_ctrl.sv
// S-100 bus controller: ce generation, status latch, window decode, boot overlay.
// Optional wait-state insertion is enabled by defining S100_WAIT_STATES_EN.
module s100_bus_ctrl #(
  parameter int CE_DIV     = 2,
  parameter int NUM_MEM    = 4,
  parameter int NUM_IO     = 2,
  parameter logic [8*NUM_MEM-1:0] MEM_BASE = {NUM_MEM{8'h00}},
  parameter logic [8*NUM_MEM-1:0] MEM_MASK = {NUM_MEM{8'hFF}},
  parameter logic [NUM_MEM-1:0]   MEM_RO   = {NUM_MEM{1'b0}},
  parameter logic [4*NUM_MEM-1:0] MEM_WAIT = {NUM_MEM{4'h0}},
  parameter logic [8*NUM_IO-1:0]  IO_BASE  = {NUM_IO{8'h00}},
  parameter logic [8*NUM_IO-1:0]  IO_MASK  = {NUM_IO{8'hFE}},
  parameter int BOOT_READS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          addr,
  input  logic [7:0]           odata,
  input  logic                 sync,
  input  logic                 rd,
  input  logic                 wr_n,
  output logic                 ce,
  output logic [7:0]           sysctl,
  output logic [7:0]           idata,
  output logic [NUM_MEM-1:0]   mem_rd,
  output logic [NUM_MEM-1:0]   mem_wr,
  input  logic [8*NUM_MEM-1:0] mem_rdata,
  output logic [NUM_IO-1:0]    io_rd,
  output logic [NUM_IO-1:0]    io_wr,
  input  logic [8*NUM_IO-1:0]  io_rdata,
  output logic                 boot_rd,
  input  logic [7:0]           boot_rdata,
  output logic                 boot_active
);

  logic [3:0] div_cnt_q, div_cnt_d;
  logic [7:0] sysctl_q, sysctl_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic       boot_active_q, boot_active_d;
  logic       rd_q, rd_d;
  logic       bsel_q, bsel_d;
  logic       wrap, ce_int, io_cyc, boot_hit;
  logic [NUM_MEM-1:0] mem_sel;
  logic [NUM_IO-1:0]  io_sel;
  logic       mem_found, io_found, mem_ro;
  logic [7:0] mem_data, io_data;
`ifdef S100_WAIT_STATES_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] mem_wait;
`endif

  assign wrap = div_cnt_q == 4'(CE_DIV - 1);
`ifdef S100_WAIT_STATES_EN
  assign ce_int = wrap && (wait_cnt_q == 4'd0);
`else
  assign ce_int = wrap;
`endif
  assign ce          = ce_int & reset_n;
  assign sysctl      = sysctl_q;
  assign boot_active = boot_active_q;
  assign io_cyc      = sysctl_q[6] | sysctl_q[4];
  assign boot_hit    = boot_active_q & ~io_cyc & rd & reset_n;

  // Priority decode: the lowest matching window claims the cycle.
  always_comb begin
    mem_sel   = '0;
    mem_found = 1'b0;
    mem_ro    = 1'b0;
    mem_data  = 8'hFF;
`ifdef S100_WAIT_STATES_EN
    mem_wait  = 4'h0;
`endif
    for (int i = 0; i < NUM_MEM; i++) begin
      if (!mem_found &&
          ((addr[15:8] & MEM_MASK[8*i +: 8]) ==
           (MEM_BASE[8*i +: 8] & MEM_MASK[8*i +: 8]))) begin
        mem_sel[i] = 1'b1;
        mem_found  = 1'b1;
        mem_ro     = MEM_RO[i];
        mem_data   = mem_rdata[8*i +: 8];
`ifdef S100_WAIT_STATES_EN
        mem_wait   = MEM_WAIT[4*i +: 4];
`endif
      end
    end
  end

  always_comb begin
    io_sel   = '0;
    io_found = 1'b0;
    io_data  = 8'hFF;
    for (int j = 0; j < NUM_IO; j++) begin
      if (!io_found &&
          ((addr[7:0] & IO_MASK[8*j +: 8]) ==
           (IO_BASE[8*j +: 8] & IO_MASK[8*j +: 8]))) begin
        io_sel[j] = 1'b1;
        io_found  = 1'b1;
        io_data   = io_rdata[8*j +: 8];
      end
    end
  end

  always_comb begin
    boot_rd = 1'b0;
    idata   = 8'hFF;
    mem_rd  = '0;
    mem_wr  = '0;
    io_rd   = '0;
    io_wr   = '0;
    if (reset_n) begin
      if (boot_hit) begin
        boot_rd = 1'b1;
        idata   = boot_rdata;
      end else if (!io_cyc) begin
        mem_rd = mem_sel & {NUM_MEM{rd}};
        if (rd && mem_found) idata = mem_data;
      end else if (sysctl_q[6]) begin
        io_rd = io_sel & {NUM_IO{rd}};
        if (rd && io_found) idata = io_data;
      end
      if (!io_cyc && !wr_n && !mem_ro) mem_wr = mem_sel;
      if (sysctl_q[4] && !wr_n) io_wr = io_sel;
    end
  end

  always_comb begin
    div_cnt_d     = wrap ? 4'd0 : div_cnt_q + 4'd1;
    sysctl_d      = (sync && ce_int) ? odata : sysctl_q;
    rd_d          = rd;
    bsel_d        = boot_active_q & ~io_cyc;
    boot_cnt_d    = boot_cnt_q;
    boot_active_d = boot_active_q && (boot_cnt_q != 4'(BOOT_READS));
    if (boot_active_q && bsel_q && rd_q && !rd &&
        boot_cnt_q != 4'(BOOT_READS))
      boot_cnt_d = boot_cnt_q + 4'd1;
`ifdef S100_WAIT_STATES_EN
    wait_cnt_d = wait_cnt_q;
    // Status bit 7 (MEMR) marks a read, which the overlay serves without waits.
    if (sync && ce_int && mem_found && !odata[6] && !odata[4] &&
        !(boot_active_q && odata[7]))
      wait_cnt_d = mem_wait;
    else if (wrap && wait_cnt_q != 4'd0)
      wait_cnt_d = wait_cnt_q - 4'd1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q     <= 4'd0;
      sysctl_q      <= 8'h00;
      boot_cnt_q    <= 4'd0;
      boot_active_q <= 1'b1;
      rd_q          <= 1'b0;
      bsel_q        <= 1'b0;
`ifdef S100_WAIT_STATES_EN
      wait_cnt_q    <= 4'd0;
`endif
    end else begin
      div_cnt_q     <= div_cnt_d;
      sysctl_q      <= sysctl_d;
      boot_cnt_q    <= boot_cnt_d;
      boot_active_q <= boot_active_d;
      rd_q          <= rd_d;
      bsel_q        <= bsel_d;
`ifdef S100_WAIT_STATES_EN
      wait_cnt_q    <= wait_cnt_d;
`endif
    end
  end

endmodule
